usb_tx_control_fsm: RTL and testbench

Transmit-side control for the USB full-speed CDL. It accepts a packet request from the protocol layer and serialises the packet bit by bit, LSB first, to the bit-stuffer/NRZI encoder. The serialised packet is SYNC, PID, optional data payload pulled from the shared data buffer, CRC16, and finally EOP. It is the transmit counterpart of the RX control FSM and shares that block's PID encodings and packet-type codes.

---
 rtl/usb_pkg.sv | 56 +++++
 rtl/usb_crc16.sv | 19 +
 rtl/usb_tx_control_fsm.sv | 167 ++++++++++++++++
 tb/tb_usb_tx_control_fsm.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// Shared USB CDL definitions: packet-type codes, PID bytes, SYNC pattern, CRC16 constants and helpers.
package usb_pkg;

  localparam logic [2:0] PKT_NONE  = 3'd0;
  localparam logic [2:0] PKT_DATA0 = 3'd1;
  localparam logic [2:0] PKT_DATA1 = 3'd2;
  localparam logic [2:0] PKT_ACK   = 3'd3;
  localparam logic [2:0] PKT_NAK   = 3'd4;
  localparam logic [2:0] PKT_STALL = 3'd5;

  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_DATA1 = 8'h4B;
  localparam logic [7:0] PID_ACK   = 8'hD2;
  localparam logic [7:0] PID_NAK   = 8'h5A;
  localparam logic [7:0] PID_STALL = 8'h1E;

  localparam logic [7:0]  SYNC_BYTE  = 8'h80;
  localparam logic [15:0] CRC16_POLY = 16'h8005;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  typedef enum logic [3:0] {
    S_IDLE, S_SYNC, S_PID, S_DATA, S_CRC_LO, S_CRC_HI, S_EOP, S_IDLE_J, S_DONE
  } tx_state_t;

  function automatic logic [7:0] pid_byte(input logic [2:0] pkt);
    case (pkt)
      PKT_DATA0: return PID_DATA0;
      PKT_DATA1: return PID_DATA1;
      PKT_ACK:   return PID_ACK;
      PKT_NAK:   return PID_NAK;
      default:   return PID_STALL;
    endcase
  endfunction

  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
    logic fb;
    fb = din ^ crc[15];
    return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
  endfunction

  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  // The serialiser is LSB-first, so each CRC byte is bit-reversed to send its MSB first.
  function automatic logic [7:0] crc_byte_hi(input logic [15:0] crc);
    return rev8(~crc[15:8]);
  endfunction

  function automatic logic [7:0] crc_byte_lo(input logic [15:0] crc);
    return rev8(~crc[7:0]);
  endfunction

endpackage

// File: rtl/usb_crc16.sv
// Serial CRC16 LFSR (x^16+x^15+x^2+1), one data bit per enable.
module usb_crc16
  import usb_pkg::*;
(
  input  logic        clk,
  input  logic        n_rst,
  input  logic        clear,
  input  logic        enable,
  input  logic        data_in,
  output logic [15:0] crc
);

  always_ff @(posedge clk) begin
    if (!n_rst)      crc <= CRC16_INIT;
    else if (clear)  crc <= CRC16_INIT;
    else if (enable) crc <= crc16_step(crc, data_in);
  end

endmodule

// File: rtl/usb_tx_control_fsm.sv
// USB full-speed transmit control: serialises SYNC, PID, payload, CRC16 and EOP LSB-first
// to the bit-stuffer, pulling payload bytes from the shared data buffer.
module usb_tx_control_fsm
  import usb_pkg::*;
#(
  parameter int MAX_BYTES = 64
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [2:0] tx_packet,
  input  logic [6:0] buffer_occupancy,
  input  logic [7:0] tx_packet_data,
  input  logic       bit_strobe,
  output logic       get_tx_packet_data,
  output logic       tx_bit,
  output logic       tx_eop,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam logic [6:0] MAX_LEN = 7'(MAX_BYTES);

  tx_state_t   state, state_nxt;
  logic [7:0]  shreg, shreg_nxt;
  logic [2:0]  bit_cnt, bit_cnt_nxt;
  logic [6:0]  byte_cnt, byte_cnt_nxt;
  logic [6:0]  len, len_nxt;
  logic [2:0]  pkt, pkt_nxt;
  logic [15:0] crc;
  logic        crc_clear, crc_en;
  logic        byte_done, is_data;

  assign byte_done = bit_strobe && (bit_cnt == 3'd7);
  assign is_data   = (pkt == PKT_DATA0) || (pkt == PKT_DATA1);

  usb_crc16 u_crc (
    .clk     (clk),
    .n_rst   (n_rst),
    .clear   (crc_clear),
    .enable  (crc_en),
    .data_in (shreg[0]),
    .crc     (crc)
  );

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state    <= S_IDLE;
      shreg    <= 8'h00;
      bit_cnt  <= 3'd0;
      byte_cnt <= 7'd0;
      len      <= 7'd0;
      pkt      <= PKT_NONE;
    end else begin
      state    <= state_nxt;
      shreg    <= shreg_nxt;
      bit_cnt  <= bit_cnt_nxt;
      byte_cnt <= byte_cnt_nxt;
      len      <= len_nxt;
      pkt      <= pkt_nxt;
    end
  end

  always_comb begin
    state_nxt          = state;
    shreg_nxt          = shreg;
    bit_cnt_nxt        = bit_cnt;
    byte_cnt_nxt       = byte_cnt;
    len_nxt            = len;
    pkt_nxt            = pkt;
    crc_clear          = 1'b0;
    crc_en             = 1'b0;
    get_tx_packet_data = 1'b0;
    tx_bit             = shreg[0];
    tx_eop             = 1'b0;
    tx_busy            = 1'b1;
    tx_done            = 1'b0;

    // Strobes only advance the serialiser while a packet is on the wire.
    if (bit_strobe && state != S_IDLE && state != S_IDLE_J && state != S_DONE) begin
      shreg_nxt   = {1'b0, shreg[7:1]};
      bit_cnt_nxt = bit_cnt + 3'd1;
    end

    case (state)
      S_IDLE: begin
        tx_bit  = 1'b1;
        tx_busy = 1'b0;
        if (tx_packet >= PKT_DATA0 && tx_packet <= PKT_STALL) begin
          pkt_nxt      = tx_packet;
          len_nxt      = 7'd0;
          if (tx_packet == PKT_DATA0 || tx_packet == PKT_DATA1)
            len_nxt = (buffer_occupancy > MAX_LEN) ? MAX_LEN : buffer_occupancy;
          shreg_nxt    = SYNC_BYTE;
          bit_cnt_nxt  = 3'd0;
          byte_cnt_nxt = 7'd0;
          crc_clear    = 1'b1;
          state_nxt    = S_SYNC;
        end
      end
      S_SYNC: begin
        if (byte_done) begin
          shreg_nxt = pid_byte(pkt);
          state_nxt = S_PID;
        end
      end
      S_PID: begin
        if (byte_done) begin
          if (!is_data) begin
            state_nxt = S_EOP;
          end else if (len == 7'd0) begin
            shreg_nxt = crc_byte_hi(crc);
            state_nxt = S_CRC_LO;
          end else begin
            shreg_nxt          = tx_packet_data;
            get_tx_packet_data = 1'b1;
            byte_cnt_nxt       = 7'd1;
            crc_clear          = 1'b1;
            state_nxt          = S_DATA;
          end
        end
      end
      S_DATA: begin
        crc_en = bit_strobe;
        if (byte_done) begin
          if (byte_cnt < len) begin
            shreg_nxt          = tx_packet_data;
            get_tx_packet_data = 1'b1;
            byte_cnt_nxt       = byte_cnt + 7'd1;
          end else begin
            // The last data bit enters the CRC on this same edge, so fold it in here.
            shreg_nxt = crc_byte_hi(crc16_step(crc, shreg[0]));
            state_nxt = S_CRC_LO;
          end
        end
      end
      S_CRC_LO: begin
        if (byte_done) begin
          shreg_nxt = crc_byte_lo(crc);
          state_nxt = S_CRC_HI;
        end
      end
      S_CRC_HI: begin
        if (byte_done) state_nxt = S_EOP;
      end
      S_EOP: begin
        tx_bit = 1'b1;
        tx_eop = 1'b1;
        if (bit_strobe && bit_cnt == 3'd1) begin
          bit_cnt_nxt = 3'd0;
          state_nxt   = S_IDLE_J;
        end
      end
      S_IDLE_J: begin
        tx_bit = 1'b1;
        if (bit_strobe) state_nxt = S_DONE;
      end
      S_DONE: begin
        tx_bit    = 1'b1;
        tx_busy   = 1'b0;
        tx_done   = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_usb_tx_control_fsm.sv
// Directed bench for usb_tx_control_fsm: bitstream, EOP/J/done timing, pop counts, reset abort.
module tb_usb_tx_control_fsm;

  logic       clk = 1'b0;
  logic       n_rst;
  logic [2:0] tx_packet;
  logic [6:0] buffer_occupancy;
  logic [7:0] tx_packet_data;
  logic       bit_strobe;
  logic       get_tx_packet_data, tx_bit, tx_eop, tx_busy, tx_done;

  logic [7:0] buf_mem [0:127];
  logic [6:0] head = 7'd0;
  int         pops = 0;
  int         checks = 0;
  int         failures = 0;
  logic       exp_bits[$];

  always #5 clk = ~clk;

  usb_tx_control_fsm #(.MAX_BYTES(64)) dut (
    .clk                (clk),
    .n_rst              (n_rst),
    .tx_packet          (tx_packet),
    .buffer_occupancy   (buffer_occupancy),
    .tx_packet_data     (tx_packet_data),
    .bit_strobe         (bit_strobe),
    .get_tx_packet_data (get_tx_packet_data),
    .tx_bit             (tx_bit),
    .tx_eop             (tx_eop),
    .tx_busy            (tx_busy),
    .tx_done            (tx_done)
  );

  // Buffer model: head advances on the edge where the pop strobe is high.
  assign tx_packet_data = buf_mem[head];
  always @(posedge clk) begin
    if (get_tx_packet_data) begin
      head <= head + 7'd1;
      pops <= pops + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) exp_bits.push_back(b[i]);
  endtask

  task automatic strobe_gap(input int gap_lo, input int gap_hi);
    int gap;
    gap = $urandom_range(gap_hi, gap_lo);
    repeat (gap) step();
  endtask

  // Reflected CRC-16/USB (poly 0xA001, init FFFF, output complemented); wire order is its LSB first.
  task automatic send_packet(input logic [2:0] code, input logic [6:0] occ,
                             input int gap_lo, input int gap_hi,
                             input int abort_at, input logic busy_poke);
    int         len, base, done_seen;
    logic [15:0] c;
    logic [7:0]  pidb, d;
    len = (code == 3'd1 || code == 3'd2) ? ((occ > 7'd64) ? 64 : int'(occ)) : 0;
    case (code)
      3'd1:    pidb = 8'hC3;
      3'd2:    pidb = 8'h4B;
      3'd3:    pidb = 8'hD2;
      3'd4:    pidb = 8'h5A;
      default: pidb = 8'h1E;
    endcase
    exp_bits.delete();
    push_byte(8'h80);
    push_byte(pidb);
    c = 16'hFFFF;
    for (int i = 0; i < len; i++) begin
      d = buf_mem[7'(int'(head) + i)];
      push_byte(d);
      c = c ^ {8'h00, d};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    if (code == 3'd1 || code == 3'd2) begin
      c = ~c;
      push_byte(c[7:0]);
      push_byte(c[15:8]);
    end

    base = pops;
    tx_packet = code;
    buffer_occupancy = occ;
    step();
    if (busy_poke) begin
      tx_packet = 3'd2;
      buffer_occupancy = 7'd5;
    end else begin
      tx_packet = 3'd0;
    end
    check("busy_after_accept", 32'(tx_busy), 32'd1);

    for (int i = 0; i < exp_bits.size(); i++) begin
      if (i == abort_at) begin
        n_rst = 1'b0;
        step();
        check("rst_tx_busy", 32'(tx_busy), 32'd0);
        check("rst_tx_bit", 32'(tx_bit), 32'd1);
        check("rst_tx_eop", 32'(tx_eop), 32'd0);
        check("rst_tx_done", 32'(tx_done), 32'd0);
        check("rst_get", 32'(get_tx_packet_data), 32'd0);
        n_rst = 1'b1;
        done_seen = 0;
        repeat (30) begin
          bit_strobe = 1'b1;
          step();
          if (tx_done) done_seen++;
        end
        bit_strobe = 1'b0;
        check("abort_no_done", 32'(done_seen), 32'd0);
        return;
      end
      strobe_gap(gap_lo, gap_hi);
      check($sformatf("bit%0d", i), 32'(tx_bit), 32'(exp_bits[i]));
      check("eop_low_in_body", 32'(tx_eop), 32'd0);
      bit_strobe = 1'b1;
      step();
      bit_strobe = 1'b0;
    end
    tx_packet = 3'd0;
    buffer_occupancy = 7'd0;

    for (int e = 0; e < 2; e++) begin
      strobe_gap(gap_lo, gap_hi);
      check("eop_high", 32'(tx_eop), 32'd1);
      check("eop_busy", 32'(tx_busy), 32'd1);
      bit_strobe = 1'b1;
      step();
      bit_strobe = 1'b0;
    end
    strobe_gap(gap_lo, gap_hi);
    check("j_eop_low", 32'(tx_eop), 32'd0);
    check("j_bit", 32'(tx_bit), 32'd1);
    check("j_busy", 32'(tx_busy), 32'd1);
    check("j_no_done", 32'(tx_done), 32'd0);
    bit_strobe = 1'b1;
    step();
    bit_strobe = 1'b0;
    check("done_pulse", 32'(tx_done), 32'd1);
    check("done_busy_low", 32'(tx_busy), 32'd0);
    step();
    check("done_single", 32'(tx_done), 32'd0);
    check("pop_count", 32'(pops - base), 32'(len));
  endtask

  initial begin
    n_rst = 1'b0;
    tx_packet = 3'd0;
    buffer_occupancy = 7'd0;
    bit_strobe = 1'b0;
    for (int i = 0; i < 128; i++) buf_mem[i] = 8'(i * 37 + 11);
    repeat (3) step();
    check("reset_tx_bit", 32'(tx_bit), 32'd1);
    check("reset_tx_eop", 32'(tx_eop), 32'd0);
    check("reset_tx_busy", 32'(tx_busy), 32'd0);
    check("reset_tx_done", 32'(tx_done), 32'd0);
    check("reset_get", 32'(get_tx_packet_data), 32'd0);
    n_rst = 1'b1;
    step();

    // Code 6 is not a request; a strobe while idle does nothing.
    tx_packet = 3'd6;
    step();
    tx_packet = 3'd0;
    check("ignore_code6", 32'(tx_busy), 32'd0);
    bit_strobe = 1'b1;
    step();
    bit_strobe = 1'b0;
    check("idle_strobe", 32'(tx_busy), 32'd0);

    // ACK, strobe every 4 cycles.
    send_packet(3'd3, 7'd0, 3, 3, -1, 1'b0);
    // DATA0, empty payload: CRC field all zero.
    send_packet(3'd1, 7'd0, 0, 2, -1, 1'b0);
    // DATA1 with 2 bytes, gap-free then random gaps.
    buf_mem[head] = 8'h01;
    buf_mem[head + 7'd1] = 8'h02;
    send_packet(3'd2, 7'd2, 0, 0, -1, 1'b0);
    buf_mem[head] = 8'h01;
    buf_mem[head + 7'd1] = 8'h02;
    send_packet(3'd2, 7'd2, 0, 19, -1, 1'b0);
    // Reset mid-payload (12 bits into the data), then a NAK.
    send_packet(3'd2, 7'd3, 0, 1, 28, 1'b0);
    send_packet(3'd4, 7'd0, 1, 1, -1, 1'b0);
    // Oversized occupancy clamps to 64; request changes while busy are ignored.
    send_packet(3'd1, 7'd70, 0, 0, -1, 1'b1);

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
